// File: rtl/bus_protocol_checker.sv
// Purpose : per-channel 4-phase rq/ack protocol checker with sticky error flags and rd/wr counters.
// Latency : flags and counters update at the sampling edge; irq follows one cycle after a flag sets.
// Backpr. : none, passive observer; it never stalls the channels it watches.
//
// Ports: clk, reset (async, active-low); client_rq/ack/wr_ni (1 bit per channel);
//        client_address/client_dataW (channel i at [i*W +: W]); err_clear (sync pulse);
//        err_status (4 flags/channel: ack_no_rq, rq_drop, field_change, timeout);
//        err_multi_ack; rd_count/wr_count (CNT_WIDTH per channel); irq.
// Optional: define BUS_PROTOCOL_CHECKER_DISPLAY_EN for simulation-only transaction/error messages.
module bus_protocol_checker #(
   parameter int NUM_CLIENTS    = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CLIENTS-1:0]            client_rq,
   input  logic [NUM_CLIENTS-1:0]            client_ack,
   input  logic [NUM_CLIENTS-1:0]            client_wr_ni,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataW,
   input  logic                              err_clear,
   output logic [NUM_CLIENTS*4-1:0]          err_status,
   output logic                              err_multi_ack,
   output logic [NUM_CLIENTS*CNT_WIDTH-1:0]  rd_count,
   output logic [NUM_CLIENTS*CNT_WIDTH-1:0]  wr_count,
   output logic                              irq
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACKD, ST_RELEASE} state_t;

   for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_ch
      state_t                st_q, st_d;
      logic [ADDR_WIDTH-1:0] addr_q;
      logic                  wr_ni_q;
      logic [DATA_WIDTH-1:0] data_q;
      logic [TMR_W-1:0]      tmr_q, tmr_d;
      logic [CNT_WIDTH-1:0]  rd_q, wr_q;
      logic [3:0]            flag_q, set_d;
      logic                  capture, cnt_rd, cnt_wr;
      logic                  rq, ack, wr_in, fields_differ;
      logic [ADDR_WIDTH-1:0] addr_in;
      logic [DATA_WIDTH-1:0] data_in;

      assign rq      = client_rq[g];
      assign ack     = client_ack[g];
      assign wr_in   = client_wr_ni[g];
      assign addr_in = client_address[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_in = client_dataW[g*DATA_WIDTH +: DATA_WIDTH];
      assign fields_differ = (addr_in != addr_q) || (wr_in != wr_ni_q) || (data_in != data_q);

      always_comb begin
         st_d    = st_q;
         tmr_d   = tmr_q;
         set_d   = '0;
         capture = 1'b0;
         cnt_rd  = 1'b0;
         cnt_wr  = 1'b0;
         case (st_q)
            ST_IDLE: begin
               if (rq) begin
                  capture = 1'b1;
                  if (ack) begin
                     // Request and ack in the same sample: served immediately.
                     st_d   = ST_ACKD;
                     cnt_rd = wr_in;
                     cnt_wr = !wr_in;
                  end else begin
                     st_d  = ST_REQ;
                     tmr_d = '0;
                  end
               end else if (ack) begin
                  set_d[0] = 1'b1;
               end
            end
            ST_REQ: begin
               if (ack) begin
                  st_d   = ST_ACKD;
                  cnt_rd = wr_ni_q;
                  cnt_wr = !wr_ni_q;
               end else if (!rq) begin
                  set_d[1] = 1'b1;
                  st_d     = ST_IDLE;
               end else if (TIMEOUT_CYCLES != 0 && tmr_q != TMO) begin
                  // Timer saturates at TMO so the flag fires once per wait.
                  tmr_d = tmr_q + 1'b1;
                  if (tmr_q + 1'b1 == TMO) set_d[3] = 1'b1;
               end
            end
            ST_ACKD: begin
               if (!rq) begin
                  st_d = ack ? ST_RELEASE : ST_IDLE;
               end else if (!ack) begin
                  // Ack withdrawn under a live request: back to waiting, not recounted.
                  set_d[1] = 1'b1;
                  st_d     = ST_REQ;
                  tmr_d    = '0;
               end
            end
            ST_RELEASE: begin
               if (!ack) st_d = ST_IDLE;
               else if (rq) set_d[0] = 1'b1;
            end
            default: st_d = ST_IDLE;
         endcase
         // Fields only need to be stable while the request is held; once rq
         // drops the client may legitimately change them.
         if ((st_q == ST_REQ || st_q == ST_ACKD) && rq && fields_differ) set_d[2] = 1'b1;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            st_q    <= ST_IDLE;
            tmr_q   <= '0;
            addr_q  <= '0;
            wr_ni_q <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            flag_q  <= '0;
         end else begin
            st_q  <= st_d;
            tmr_q <= tmr_d;
            if (capture) begin
               addr_q  <= addr_in;
               wr_ni_q <= wr_in;
               data_q  <= data_in;
            end
            if (cnt_rd && rd_q != '1) rd_q <= rd_q + 1'b1;
            if (cnt_wr && wr_q != '1) wr_q <= wr_q + 1'b1;
            // A new violation in the clearing cycle wins over the clear.
            flag_q <= (flag_q & {4{~err_clear}}) | set_d;
         end
      end

      assign err_status[g*4 +: 4]                = flag_q;
      assign rd_count[g*CNT_WIDTH +: CNT_WIDTH] = rd_q;
      assign wr_count[g*CNT_WIDTH +: CNT_WIDTH] = wr_q;

`ifdef BUS_PROTOCOL_CHECKER_DISPLAY_EN
      always @(posedge clk) begin
         if (reset) begin
            if (capture) begin
               if (wr_in) $display(" %0t - CLIENT %0d - READ - ADDRESS: %b", $time, g, addr_in);
               else $display(" %0t - CLIENT %0d - WRITE - ADDRESS: %b - DATA: %b", $time, g, addr_in, data_in);
            end
            if (st_d != st_q) $display(" %0t - CLIENT %0d - %s -> %s", $time, g, st_q.name(), st_d.name());
            if (cnt_rd || cnt_wr) $display(" %0t - CLIENT %0d - REQUEST SERVED", $time, g);
            if (set_d[0]) $display("PROTOCOL ERROR ON CHANNEL %0d - ACK_NO_RQ", g);
            if (set_d[1]) $display("PROTOCOL ERROR ON CHANNEL %0d - RQ_DROP", g);
            if (set_d[2]) $display("PROTOCOL ERROR ON CHANNEL %0d - FIELD_CHANGE", g);
            if (set_d[3]) $display("PROTOCOL ERROR ON CHANNEL %0d - TIMEOUT", g);
         end
      end
`endif
   end

   // Multi-ack: two or more rising acks iff the rise vector has more than one bit set.
   logic [NUM_CLIENTS-1:0] ack_prev_q, ack_rise;
   logic                   multi_set;

   assign ack_rise  = client_ack & ~ack_prev_q;
   assign multi_set = |(ack_rise & (ack_rise - 1'b1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_prev_q    <= '0;
         err_multi_ack <= 1'b0;
         irq           <= 1'b0;
      end else begin
         ack_prev_q    <= client_ack;
         err_multi_ack <= (err_multi_ack & ~err_clear) | multi_set;
         irq           <= err_clear ? 1'b0 : (|err_status | err_multi_ack);
      end
   end

endmodule

// File: tb/tb_bus_protocol_checker.sv
// Bench for bus_protocol_checker: directed scenarios followed by random rq/ack
// traffic, all compared each cycle against a transaction-level reference model.
module tb_bus_protocol_checker;
   localparam int NC = 4;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;
   localparam int CW = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic               clk;
   logic               reset_n;
   logic [NC-1:0]      rq, ack, wr_ni;
   logic [NC*AW-1:0]   addr;
   logic [NC*DW-1:0]   dataw;
   logic               err_clear;
   logic [NC*4-1:0]    err_status;
   logic               err_multi_ack;
   logic [NC*CW-1:0]   rd_count, wr_count;
   logic               irq;

   int checks = 0;
   int passed = 0;

   bus_protocol_checker #(
      .NUM_CLIENTS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset_n),
      .client_rq(rq), .client_ack(ack), .client_wr_ni(wr_ni),
      .client_address(addr), .client_dataW(dataw),
      .err_clear(err_clear),
      .err_status(err_status), .err_multi_ack(err_multi_ack),
      .rd_count(rd_count), .wr_count(wr_count), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per channel, whether a transaction is open, whether it
   // has been served, whether the requester has let go, and how long it waited.
   bit            m_open [NC];
   bit            m_served [NC];
   bit            m_let_go [NC];
   int            m_wait [NC];
   logic [AW-1:0] c_addr [NC];
   logic          c_wr [NC];
   logic [DW-1:0] c_data [NC];
   int            m_rd [NC];
   int            m_wr [NC];
   logic [3:0]    m_flags [NC];
   logic          m_multi, m_irq;
   logic [NC-1:0] m_ack_prev;

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         m_open[c] = 0; m_served[c] = 0; m_let_go[c] = 0; m_wait[c] = 0;
         c_addr[c] = '0; c_wr[c] = 0; c_data[c] = '0;
         m_rd[c] = 0; m_wr[c] = 0; m_flags[c] = '0;
      end
      m_multi = 0; m_irq = 0; m_ack_prev = '0;
   endtask

   task automatic served_count(input int c, input logic is_read);
      if (is_read) m_rd[c] = (m_rd[c] < MAXC) ? m_rd[c] + 1 : MAXC;
      else         m_wr[c] = (m_wr[c] < MAXC) ? m_wr[c] + 1 : MAXC;
   endtask

   // Apply one sampling edge with the inputs currently on the bus.
   task automatic model_step();
      logic [3:0] s;
      logic       any_old, r, a;
      int         rises;
      any_old = m_multi;
      for (int c = 0; c < NC; c++) any_old = any_old | (|m_flags[c]);
      rises = $countones(ack & ~m_ack_prev);
      for (int c = 0; c < NC; c++) begin
         s = '0;
         r = rq[c];
         a = ack[c];
         if (m_open[c] && !m_let_go[c] && r &&
             (addr[c*AW +: AW] != c_addr[c] || wr_ni[c] != c_wr[c] || dataw[c*DW +: DW] != c_data[c]))
            s[2] = 1'b1;
         if (!m_open[c]) begin
            if (r) begin
               m_open[c] = 1; m_served[c] = a; m_let_go[c] = 0; m_wait[c] = 0;
               c_addr[c] = addr[c*AW +: AW]; c_wr[c] = wr_ni[c]; c_data[c] = dataw[c*DW +: DW];
               if (a) served_count(c, wr_ni[c]);
            end else if (a) s[0] = 1'b1;
         end else if (!m_served[c]) begin
            if (a) begin
               m_served[c] = 1;
               served_count(c, c_wr[c]);
            end else if (!r) begin
               s[1] = 1'b1; m_open[c] = 0;
            end else if (m_wait[c] < TO) begin
               m_wait[c]++;
               if (m_wait[c] == TO) s[3] = 1'b1;
            end
         end else if (!m_let_go[c]) begin
            if (!r) begin
               if (a) m_let_go[c] = 1; else m_open[c] = 0;
            end else if (!a) begin
               s[1] = 1'b1; m_served[c] = 0; m_wait[c] = 0;
            end
         end else begin
            if (!a) m_open[c] = 0;
            else if (r) s[0] = 1'b1;
         end
         m_flags[c] = (err_clear ? 4'h0 : m_flags[c]) | s;
      end
      m_irq      = err_clear ? 1'b0 : any_old;
      m_multi    = (err_clear ? 1'b0 : m_multi) | (rises >= 2);
      m_ack_prev = ack;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_model();
      logic [NC*4-1:0]  e_err;
      logic [NC*CW-1:0] e_rd, e_wr;
      for (int c = 0; c < NC; c++) begin
         e_err[c*4 +: 4]  = m_flags[c];
         e_rd[c*CW +: CW] = CW'(m_rd[c]);
         e_wr[c*CW +: CW] = CW'(m_wr[c]);
      end
      chk("err_status", 64'(err_status), 64'(e_err));
      chk("err_multi_ack", 64'(err_multi_ack), 64'(m_multi));
      chk("rd_count", 64'(rd_count), 64'(e_rd));
      chk("wr_count", 64'(wr_count), 64'(e_wr));
      chk("irq", 64'(irq), 64'(m_irq));
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      model_step();
      check_model();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_err_status", 64'(err_status), 64'h0);
      chk("rst_counts", 64'({rd_count, wr_count}), 64'h0);
      chk("rst_irq_multi", 64'({irq, err_multi_ack}), 64'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      cycle();
      err_clear = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1; rq = '0; ack = '0; wr_ni = '0; addr = '0; dataw = '0; err_clear = 1'b0;
      model_reset();
      #1;
      do_reset();

      // Channel 0 clean write, ack three cycles after the request.
      rq[0] = 1; addr[3:0] = 4'h5; wr_ni[0] = 0; dataw[7:0] = 8'hA3;
      cycle(); cycle(); cycle();
      ack[0] = 1; cycle();
      rq[0] = 0;  cycle();
      ack[0] = 0; cycle();
      chk("t1_wr_count0", 64'(wr_count[1:0]), 64'd1);
      chk("t1_err_status", 64'(err_status), 64'h0);
      chk("t1_irq", 64'(irq), 64'h0);

      // Channel 2 ack without request, irq one cycle later, then clear.
      ack[2] = 1; cycle();
      chk("t2_bit8", 64'(err_status[8]), 64'd1);
      chk("t2_irq_not_yet", 64'(irq), 64'd0);
      ack[2] = 0; cycle();
      chk("t2_irq", 64'(irq), 64'd1);
      pulse_clear();
      chk("t2_cleared", 64'({irq, err_status}), 64'h0);

      // Channel 1 read with an address change before the ack.
      rq[1] = 1; addr[7:4] = 4'h3; wr_ni[1] = 1; cycle();
      addr[7:4] = 4'h4; cycle();
      chk("t3_bit6", 64'(err_status[6]), 64'd1);
      ack[1] = 1; cycle();
      chk("t3_rd_count1", 64'(rd_count[3:2]), 64'd1);
      rq[1] = 0; ack[1] = 0; cycle();
      pulse_clear();

      // Channel 3 waits 20 cycles without ack: timeout exactly at cycle 16.
      rq[3] = 1; wr_ni[3] = 0; cycle();
      for (int k = 1; k <= 20; k++) begin
         cycle();
         chk($sformatf("t4_bit15_k%0d", k), 64'(err_status[15]), 64'(k >= TO));
      end
      ack[3] = 1; cycle();
      chk("t4_late_ack_counted", 64'(wr_count[7:6]), 64'd1);
      rq[3] = 0; ack[3] = 0; cycle();
      pulse_clear();

      // Two channels acked in the same cycle from REQ.
      rq[0] = 1; rq[1] = 1; cycle();
      ack[0] = 1; ack[1] = 1; cycle();
      chk("t5_multi", 64'(err_multi_ack), 64'd1);
      chk("t5_no_chan_flags", 64'(err_status), 64'h0);
      rq[1:0] = 2'b00; ack[1:0] = 2'b00; cycle();
      cycle();
      chk("t5_irq", 64'(irq), 64'd1);
      pulse_clear();

      // Saturation at CNT_WIDTH=2, then reset in the middle of a request.
      do_reset();
      for (int n = 0; n < 5; n++) begin
         rq[0] = 1; cycle();
         ack[0] = 1; cycle();
         rq[0] = 0; ack[0] = 0; cycle();
      end
      chk("t6_wr_sat", 64'(wr_count[1:0]), 64'd3);
      rq[0] = 1; cycle();
      rq[0] = 0;
      do_reset();

      // Random traffic with occasional field changes, clears and resets.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int c = 0; c < NC; c++) begin
            rq[c]    = rq[c] ^ ($urandom_range(0, 3) == 0);
            ack[c]   = ack[c] ^ ($urandom_range(0, 3) == 0);
            wr_ni[c] = wr_ni[c] ^ ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 19) == 0) addr[c*AW +: AW] = AW'($urandom);
            if ($urandom_range(0, 19) == 0) dataw[c*DW +: DW] = DW'($urandom);
         end
         // Long quiet stretches on one channel so the timeout path is reached.
         if (cyc % 300 >= 250) begin
            rq[2] = 1; ack[2] = 0;
         end
         err_clear = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 249) == 0) begin
            err_clear = 1'b0;
            do_reset();
         end else begin
            cycle();
         end
      end
      err_clear = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/bus_protocol_checker.md
Name: bus_protocol_checker

Overview:
- Synthesizable, parametrised handshake checker and transaction counter for the bus arbiter client channels. It supports NUM_CLIENTS channels.
- Each channel has its own 4-phase rq/ack state machine. It latches sticky protocol-error flags and counts completed reads and writes.
- It sits alongside the arbiter, both in the testbench and optionally in silicon. It drives a single irq line for debug.

Parameters:
- NUM_CLIENTS, 4: number of client channels (1..16).
- DATA_WIDTH, 8: client data width.
- ADDR_WIDTH, 4: client address width.
- TIMEOUT_CYCLES, 64: maximum cycles in REQ before a timeout is flagged. 0 disables the timeout check.
- CNT_WIDTH, 16: width of each per-channel read and write counter.

Ports:
- clk  input  1  single clock; all sampling on posedge.
- reset  input  1  asynchronous, active-low reset.
- client_rq  input  NUM_CLIENTS  request, one bit per channel.
- client_ack  input  NUM_CLIENTS  acknowledge, one bit per channel.
- client_wr_ni  input  NUM_CLIENTS  1 = read, 0 = write.
- client_address  input  NUM_CLIENTS*ADDR_WIDTH  channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- client_dataW  input  NUM_CLIENTS*DATA_WIDTH  write data, packed the same way.
- err_clear  input  1  synchronous one-cycle pulse; clears all sticky error flags.
- err_status  output  NUM_CLIENTS*4  per-channel sticky flags: bit0 ack_no_rq, bit1 rq_drop, bit2 field_change, bit3 timeout.
- err_multi_ack  output  1  sticky; two or more acks rose in the same cycle.
- rd_count  output  NUM_CLIENTS*CNT_WIDTH  completed reads per channel.
- wr_count  output  NUM_CLIENTS*CNT_WIDTH  completed writes per channel.
- irq  output  1  registered OR of all error flags.

Behaviour:
- Reset (reset=0, asynchronous): all FSMs go to IDLE. All counters, timers, flags and irq go to 0. Previous-sample registers go to 0.
- Sampling and latency: rq and ack are sampled each posedge. A violation present at a sampling edge sets its flag at that edge; irq follows one cycle later.
- Channel FSM, states IDLE, REQ, ACKD, RELEASE:
  - IDLE: rq=1, ack=0 -> REQ, capturing address, wr_ni and dataW. rq=1, ack=1 -> ACKD, capturing the same fields and counting the transaction. ack=1 with rq=0 -> set ack_no_rq, stay in IDLE.
  - REQ: ack=1 -> ACKD; increment rd_count if the captured wr_ni=1, else wr_count. rq=0 with ack=0 -> set rq_drop, go to IDLE.
  - ACKD: rq=0 -> RELEASE, or IDLE if ack is also 0. ack=0 with rq=1 -> set rq_drop, go to REQ (not counted again).
  - RELEASE: ack=0 -> IDLE. rq=1 while ack=1 -> set ack_no_rq, stay in RELEASE.
- field_change: in REQ or ACKD, if address, wr_ni or dataW differs from the captured value, set field_change. Captured values are not updated.
- Timeout: the per-channel timer clears on entry to REQ and increments each cycle in REQ. When it equals TIMEOUT_CYCLES, set timeout once; the FSM stays in REQ and the timer saturates.
- Counters saturate at all-ones and never wrap.
- err_multi_ack: set when the count of channels with an ack 0->1 edge in the same cycle is 2 or more.
- err_clear: clears all sticky flags and irq. If a new violation occurs in the same cycle as err_clear, the set wins. err_clear does not affect FSMs or counters.
- Channels are fully independent. Simultaneous events on different channels are all recorded.
- Reset asserted mid-transaction aborts everything. No error is flagged for the aborted transaction.

Optional Feature:
- Macro: BUS_PROTOCOL_CHECKER_DISPLAY_EN.
- Defined: simulation-only $display on each FSM transition and each flag set. Message format: " <time> - CLIENT <i> - READ|WRITE - ADDRESS: <bin> [- DATA: <bin>]" on request, "... REQUEST SERVED" on count, and "PROTOCOL ERROR ON CHANNEL <i> - <flag>" on error.
- Undefined: no display code is compiled. Synthesized logic is identical in both cases.

Test Plan:
- Channel 0 clean write: rq=1, addr=0x5, wr_ni=0, dataW=0xA3; ack after 3 cycles; rq drops; ack drops -> wr_count[0]=1, err_status=0, irq=0.
- Channel 2 ack without request: ack pulse while rq=0 -> err_status bit8=1, irq=1 one cycle later. Then err_clear pulse -> flags=0, irq=0.
- Channel 1 field change: rq=1 with addr=0x3, then addr changes to 0x4 before ack -> field_change (bit6) set. The read still completes with rd_count[1]=1.
- Timeout: TIMEOUT_CYCLES=16, channel 3 holds rq for 20 cycles with no ack -> bit15 set exactly at cycle 16. A later ack still counts.
- Multi-ack: acks rise on channels 0 and 1 in the same cycle -> err_multi_ack=1. No per-channel flags are set if both channels were in REQ.
- Saturation and reset: CNT_WIDTH=2, 5 writes on channel 0 -> wr_count[0]=3. Assert reset mid-REQ -> all outputs 0 immediately.
